gru_seq_ctrl: RTL and testbench

GRU_SEQ_CTRL -- requirements
Module: gru_seq_ctrl

---
 rtl/gru_pkg.sv | 18 +
 rtl/gru_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_gru_seq_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/gru_pkg.sv
// Shared definitions for the GRU sequence controller.
//   GRU_DW      : default signed fixed-point width of X and hidden state
//   GRU_SEQ_MAX : default maximum number of timesteps per sequence
//   gru_state_t : sequencer FSM state encoding
package gru_pkg;

    localparam int GRU_DW      = 8;
    localparam int GRU_SEQ_MAX = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_EVAL = 3'd2,
        ST_EMIT = 3'd3,
        ST_FIN  = 3'd4
    } gru_state_t;

endpackage

// File: rtl/gru_seq_ctrl.sv
// Sequences one recurrent cell over a stream of X samples.
// Each X sample is fed to the external cell together with the current hidden
// state. After CELL_LAT cycles the cell result becomes the new hidden state.
// That hidden state is then offered on the h stream and fed back for the
// next step.
//
// Ports
//   clk, rst_n               : clock, synchronous active-low reset
//   start, seq_len, h0       : sequence request, captured only in IDLE
//   x_valid, x_data, x_ready : X sample stream (accepted in LOAD)
//   cell_x, cell_h           : cell inputs, held stable through EVAL
//   cell_h_out               : cell result, sampled in the last EVAL cycle
//   h_valid, h_data, h_last, h_ready : per-step hidden-state output stream
//   busy, done               : status; done pulses one cycle in FIN
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | waiting for an X sample
// EVAL  | cell computing, CELL_LAT cycles
// EMIT  | offering the new hidden state downstream
// FIN   | one-cycle done pulse, then back to IDLE
module gru_seq_ctrl
    import gru_pkg::*;
#(
    parameter int DW       = GRU_DW,
    parameter int SEQ_MAX  = GRU_SEQ_MAX,
    parameter int CELL_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [4:0]    seq_len,
    input  logic [DW-1:0] h0,
    input  logic          x_valid,
    input  logic [DW-1:0] x_data,
    output logic          x_ready,
    output logic [DW-1:0] cell_x,
    output logic [DW-1:0] cell_h,
    input  logic [DW-1:0] cell_h_out,
    output logic          h_valid,
    output logic [DW-1:0] h_data,
    output logic          h_last,
    input  logic          h_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [4:0] LP_SEQ_MAX   = 5'(SEQ_MAX);
    localparam logic [2:0] LP_WAIT_INIT = 3'(CELL_LAT - 1);

    gru_state_t    r_state;
    gru_state_t    w_state_nxt;
    logic [DW-1:0] r_h;
    logic [DW-1:0] r_x;
    logic [4:0]    r_step;
    logic [4:0]    r_len;
    logic [2:0]    r_wait;

    logic [4:0]    w_len_clamp;
    logic          w_last;
    logic          w_start_acc;
    logic          w_x_acc;
    logic          w_eval_end;
    logic          w_h_acc;

    assign w_len_clamp = (seq_len > LP_SEQ_MAX) ? LP_SEQ_MAX : seq_len;
    // r_len is never 0 outside IDLE/FIN, so the subtraction cannot wrap in EMIT.
    assign w_last      = (r_step == (r_len - 5'd1));
    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_x_acc     = (r_state == ST_LOAD) && x_valid;
    assign w_eval_end  = (r_state == ST_EVAL) && (r_wait == 3'd0);
    assign w_h_acc     = (r_state == ST_EMIT) && h_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        x_ready     = 1'b0;
        h_valid     = 1'b0;
        h_last      = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (w_len_clamp == 5'd0) ? ST_FIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                x_ready = 1'b1;
                if (x_valid) begin
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (r_wait == 3'd0) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                h_valid = 1'b1;
                h_last  = w_last;
                if (h_ready) begin
                    w_state_nxt = w_last ? ST_FIN : ST_LOAD;
                end
            end
            ST_FIN: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h    <= '0;
            r_x    <= '0;
            r_step <= '0;
            r_len  <= '0;
            r_wait <= '0;
        end else begin
            if (w_start_acc) begin
                r_h    <= h0;
                r_len  <= w_len_clamp;
                r_step <= '0;
            end
            if (w_x_acc) begin
                r_x    <= x_data;
                r_wait <= LP_WAIT_INIT;
            end
            if (r_state == ST_EVAL) begin
                if (w_eval_end) begin
                    r_h <= cell_h_out;
                end else begin
                    r_wait <= r_wait - 3'd1;
                end
            end
            if (w_h_acc && !w_last) begin
                r_step <= r_step + 5'd1;
            end
        end
    end

    assign cell_x = r_x;
    assign cell_h = r_h;
    assign h_data = r_h;

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// Directed bench for gru_seq_ctrl with a saturating-add cell model
// (cell_h_out = sat8(cell_h + cell_x)), evaluated combinationally so the
// result is ready by the end of the single EVAL cycle (CELL_LAT=1).
module tb_gru_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] seq_len;
    logic [7:0] h0;
    logic       x_valid;
    logic [7:0] x_data;
    logic       x_ready;
    logic [7:0] cell_x;
    logic [7:0] cell_h;
    logic [7:0] cell_h_out;
    logic       h_valid;
    logic [7:0] h_data;
    logic       h_last;
    logic       h_ready;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] xs   [32];
    logic [7:0] exps [32];

    always #5 clk = ~clk;

    gru_seq_ctrl #(.DW(8), .SEQ_MAX(16), .CELL_LAT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seq_len    (seq_len),
        .h0         (h0),
        .x_valid    (x_valid),
        .x_data     (x_data),
        .x_ready    (x_ready),
        .cell_x     (cell_x),
        .cell_h     (cell_h),
        .cell_h_out (cell_h_out),
        .h_valid    (h_valid),
        .h_data     (h_data),
        .h_last     (h_last),
        .h_ready    (h_ready),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [7:0] sat8(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] s;
        s = $signed({a[7], a}) + $signed({b[7], b});
        if (s > 9'sd127)       return 8'h7F;
        else if (s < -9'sd128) return 8'h80;
        else                   return s[7:0];
    endfunction

    assign cell_h_out = sat8(cell_h, cell_x);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_xready"}, {7'd0, x_ready}, 8'h00);
        chk({tag, "_hvalid"}, {7'd0, h_valid}, 8'h00);
        chk({tag, "_hlast"},  {7'd0, h_last},  8'h00);
        chk({tag, "_busy"},   {7'd0, busy},    8'h00);
        chk({tag, "_done"},   {7'd0, done},    8'h00);
        chk({tag, "_hdata"},  h_data,          8'h00);
        chk({tag, "_cellx"},  cell_x,          8'h00);
        chk({tag, "_cellh"},  cell_h,          8'h00);
    endtask

    // Runs one full sequence. gap_step: step whose X arrives 3 cycles late;
    // hold_step: step whose EMIT is back-pressured for 5 cycles (-1 = none).
    task automatic run_seq(input logic [7:0] h0v, input logic [4:0] lenv, input int nexp,
                           input int gap_step, input int hold_step);
        logic [7:0] prev;
        prev    = h0v;
        start   = 1'b1;
        seq_len = lenv;
        h0      = h0v;
        tick();
        start   = 1'b0;
        for (int k = 0; k < nexp; k++) begin
            chk("load_busy", {7'd0, busy}, 8'h01);
            if (k == gap_step) begin
                for (int g = 0; g < 3; g++) begin
                    chk("gap_xready", {7'd0, x_ready}, 8'h01);
                    chk("gap_hvalid", {7'd0, h_valid}, 8'h00);
                    tick();
                end
            end
            x_valid = 1'b1;
            x_data  = xs[k];
            chk("load_xready", {7'd0, x_ready}, 8'h01);
            tick();
            x_valid = 1'b0;
            x_data  = 8'h00;
            chk("eval_xready", {7'd0, x_ready}, 8'h00);
            chk("eval_hvalid", {7'd0, h_valid}, 8'h00);
            chk("eval_cellx",  cell_x, xs[k]);
            chk("eval_cellh",  cell_h, prev);
            if (k == hold_step) h_ready = 1'b0;
            tick();
            chk("emit_hvalid", {7'd0, h_valid}, 8'h01);
            chk("emit_hdata",  h_data, exps[k]);
            chk("emit_hlast",  {7'd0, h_last}, (k == nexp - 1) ? 8'h01 : 8'h00);
            if (k == hold_step) begin
                for (int w = 0; w < 5; w++) begin
                    tick();
                    chk("hold_hvalid", {7'd0, h_valid}, 8'h01);
                    chk("hold_hdata",  h_data, exps[k]);
                    chk("hold_hlast",  {7'd0, h_last}, (k == nexp - 1) ? 8'h01 : 8'h00);
                    chk("hold_xready", {7'd0, x_ready}, 8'h00);
                    chk("hold_cellh",  cell_h, exps[k]);
                end
                h_ready = 1'b1;
            end
            prev = exps[k];
            tick();
        end
        chk("fin_done", {7'd0, done}, 8'h01);
        chk("fin_busy", {7'd0, busy}, 8'h01);
        tick();
        chk("idle_done", {7'd0, done}, 8'h00);
        chk("idle_busy", {7'd0, busy}, 8'h00);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        seq_len = 5'd0;
        h0      = 8'h00;
        x_valid = 1'b0;
        x_data  = 8'h00;
        h_ready = 1'b1;
        tick();
        tick();
        chk_all_zero("rst");
        rst_n = 1'b1;
        tick();

        // basic three-step sequence
        xs[0] = 8'h10; xs[1] = 8'h20; xs[2] = 8'h01;
        exps[0] = 8'h10; exps[1] = 8'h30; exps[2] = 8'h31;
        run_seq(8'h00, 5'd3, 3, -1, -1);

        // zero-length sequence goes straight to FIN
        start   = 1'b1;
        seq_len = 5'd0;
        h0      = 8'h55;
        tick();
        start   = 1'b0;
        chk("len0_done",   {7'd0, done},    8'h01);
        chk("len0_busy",   {7'd0, busy},    8'h01);
        chk("len0_xready", {7'd0, x_ready}, 8'h00);
        chk("len0_hvalid", {7'd0, h_valid}, 8'h00);
        tick();
        chk("len0_done2",  {7'd0, done},    8'h00);
        chk("len0_busy2",  {7'd0, busy},    8'h00);
        chk("len0_hvalid2",{7'd0, h_valid}, 8'h00);

        // over-length request clamps to 16 beats
        for (int i = 0; i < 16; i++) begin
            xs[i]   = 8'h01;
            exps[i] = 8'(i + 1);
        end
        run_seq(8'h00, 5'd20, 16, -1, -1);
        chk("clamp_hvalid_after", {7'd0, h_valid}, 8'h00);

        // back-pressure in EMIT of step 1, then gapped X on step 1
        xs[0] = 8'h10; xs[1] = 8'h20; xs[2] = 8'h01;
        exps[0] = 8'h10; exps[1] = 8'h30; exps[2] = 8'h31;
        run_seq(8'h00, 5'd3, 3, -1, 1);
        run_seq(8'h00, 5'd3, 3, 1, -1);

        // saturation: 0x70 + 0x20 clamps to 0x7F, then 0x7F + 0x80 = 0xFF
        xs[0] = 8'h20; xs[1] = 8'h80;
        exps[0] = 8'h7F; exps[1] = 8'hFF;
        run_seq(8'h70, 5'd2, 2, -1, -1);

        // reset while evaluating step 1
        start   = 1'b1;
        seq_len = 5'd3;
        h0      = 8'h00;
        tick();
        start   = 1'b0;
        x_valid = 1'b1;
        x_data  = 8'h10;
        tick();
        x_valid = 1'b0;
        tick();
        chk("mid_emit_hdata", h_data, 8'h10);
        tick();
        x_valid = 1'b1;
        x_data  = 8'h20;
        tick();
        x_valid = 1'b0;
        chk("mid_eval_busy", {7'd0, busy}, 8'h01);
        rst_n = 1'b0;
        tick();
        chk_all_zero("midrst");
        rst_n = 1'b1;
        tick();
        chk("midrst_done", {7'd0, done}, 8'h00);
        chk("midrst_hvalid", {7'd0, h_valid}, 8'h00);

        xs[0]   = 8'h01;
        exps[0] = 8'h81;
        run_seq(8'h80, 5'd1, 1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
